dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_pkg
// Brief    : Shared encodings for the data-memory responder: funct3 access
//            sizes, access direction and FSM state codes.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    // funct3 access-size encodings (loads and stores share 000/001/010)
    localparam logic [2:0] c_f3_byte  = 3'b000;  // LB / SB
    localparam logic [2:0] c_f3_half  = 3'b001;  // LH / SH
    localparam logic [2:0] c_f3_word  = 3'b010;  // LW / SW
    localparam logic [2:0] c_f3_ubyte = 3'b100;  // LBU (load only)
    localparam logic [2:0] c_f3_uhalf = 3'b101;  // LHU (load only)

    // Access direction
    localparam logic c_rw_read  = 1'b0;
    localparam logic c_rw_write = 1'b1;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;
    localparam logic [1:0] c_st_err  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : Word-organised storage with a synchronous byte-enabled write
//            port and an asynchronous word read port. Contents are never
//            reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Byte-lane write: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory responder. Captures a request in
//            IDLE, rejects illegal ones through a one-cycle ERR response,
//            otherwise waits WAIT_CYCLES+1 busy cycles and responds for one
//            cycle, committing stores on the edge that ends the response.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        RW,
    input  logic [31:0] addr,
    input  logic [31:0] dataIN,
    input  logic [2:0]  funct3,
    output logic [31:0] dataOUT,
    output logic        ready,
    output logic        err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] c_depth = 32'(DEPTH);
    localparam logic [3:0]  c_wait  = 4'(WAIT_CYCLES);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [2:0]    f3_q, f3_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          w_f3_ok;
    logic          w_align_ok;
    logic          w_range_ok;
    logic          w_legal;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    // Legality of the request currently on the inputs: encoding and alignment
    always_comb begin
        w_f3_ok    = 1'b0;
        w_align_ok = 1'b1;
        case (funct3)
            c_f3_byte:  w_f3_ok = 1'b1;
            c_f3_half: begin
                w_f3_ok    = 1'b1;
                w_align_ok = ~addr[0];
            end
            c_f3_word: begin
                w_f3_ok    = 1'b1;
                w_align_ok = (addr[1:0] == 2'b00);
            end
            c_f3_ubyte: w_f3_ok = (RW == c_rw_read);
            c_f3_uhalf: begin
                w_f3_ok    = (RW == c_rw_read);
                w_align_ok = ~addr[0];
            end
            default:    w_f3_ok = 1'b0;
        endcase
    end

    // Word index must fall inside the array; upper address bits are not aliased
    assign w_range_ok = ({2'b00, addr[31:2]} < c_depth);
    assign w_legal    = w_f3_ok & w_align_ok & w_range_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (en) begin
                    state_d = w_legal ? c_st_busy : c_st_err;
                end
            end
            c_st_busy: begin
                if (cnt_q == 4'd0) begin
                    state_d = c_st_resp;
                end
            end
            c_st_resp: state_d = c_st_idle;
            c_st_err:  state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    // Request capture in IDLE and busy-cycle countdown
    always_comb begin
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == c_st_idle && en) begin
            rw_d    = RW;
            f3_d    = funct3;
            addr_d  = addr[AW+1:0];
            wdata_d = dataIN;
            cnt_d   = c_wait;
        end else if (state_q == c_st_busy && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Request and counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            rw_q    <= c_rw_read;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Store lane steering; only legal store sizes ever reach RESP
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_q[1:0];
                w_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_q[15:0]}};
            end
            default: w_be = 4'b1111;
        endcase
    end

    // Commit on the edge closing RESP; a reset on that same edge suppresses it
    assign w_we = (state_q == c_st_resp) && (rw_q == c_rw_write) && rst;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (w_we),
        .be_i    (w_be),
        .waddr_i (addr_q[AW+1:2]),
        .wdata_i (w_wdata),
        .raddr_i (addr_q[AW+1:2]),
        .rdata_o (w_rdata)
    );

    assign w_byte = w_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign w_half = addr_q[1] ? w_rdata[31:16] : w_rdata[15:0];

    // Load lane extraction with sign or zero extension
    always_comb begin
        w_load = 32'h0;
        case (f3_q)
            c_f3_byte:  w_load = {{24{w_byte[7]}}, w_byte};
            c_f3_half:  w_load = {{16{w_half[15]}}, w_half};
            c_f3_word:  w_load = w_rdata;
            c_f3_ubyte: w_load = {24'h0, w_byte};
            c_f3_uhalf: w_load = {16'h0, w_half};
            default:    w_load = 32'h0;
        endcase
    end

    // Response outputs decoded from the current state
    always_comb begin
        ready   = 1'b0;
        err     = 1'b0;
        dataOUT = 32'h0;
        case (state_q)
            c_st_resp: begin
                ready = 1'b1;
                if (rw_q == c_rw_read) begin
                    dataOUT = w_load;
                end
            end
            c_st_err: begin
                ready = 1'b1;
                err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Scoreboard bench for dmem_responder. Three instances with
//            WAIT_CYCLES = 1, 3 and 0. Stimulus pushes expected responses;
//            a negedge monitor pops and checks data, err and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_v = 3'b000;
    logic [2:0]  en_v  = 3'b000;
    logic [2:0]  rw_v  = 3'b000;
    logic [2:0]  rdy_v;
    logic [2:0]  err_v;
    logic [31:0] addr_a [3];
    logic [31:0] din_a  [3];
    logic [2:0]  f3_a   [3];
    logic [31:0] dout_a [3];

    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t m_e;
    int   m_lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .RW(rw_v[0]), .addr(addr_a[0]),
        .dataIN(din_a[0]), .funct3(f3_a[0]), .dataOUT(dout_a[0]), .ready(rdy_v[0]), .err(err_v[0]));
    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .RW(rw_v[1]), .addr(addr_a[1]),
        .dataIN(din_a[1]), .funct3(f3_a[1]), .dataOUT(dout_a[1]), .ready(rdy_v[1]), .err(err_v[1]));
    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .RW(rw_v[2]), .addr(addr_a[2]),
        .dataIN(din_a[2]), .funct3(f3_a[2]), .dataOUT(dout_a[2]), .ready(rdy_v[2]), .err(err_v[2]));

    // Edges from en-sampling edge to the edge that samples ready=1
    function automatic int lat_of(input int d, input logic xe);
        if (xe) return 1;
        case (d)
            0:       return 3;
            1:       return 5;
            default: return 2;
        endcase
    endfunction

    // Expected response for a request whose en is sampled on the next posedge
    task automatic push_exp(input int d, input logic [31:0] xd, input logic xe);
        exp_t e;
        e.dut   = d;
        e.data  = xd;
        e.err   = xe;
        e.issue = cyc + 1;
        e.lat   = lat_of(d, xe);
        exp_q.push_back(e);
    endtask

    // Issue one request, wait (bounded) for its response, optional reset on RESP
    task automatic do_req(input int d, input logic rw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] xd, input logic xe, input bit rst_on_resp);
        bit got;
        @(negedge clk);
        rw_v[d] = rw; f3_a[d] = f3; addr_a[d] = a; din_a[d] = wd; en_v[d] = 1'b1;
        push_exp(d, xd, xe);
        @(negedge clk);
        en_v[d] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rdy_v[d]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            n_check++; n_fail++;
            $display("FAIL timeout dut%0d addr=%h: no ready within 40 cycles, required a response", d, a);
        end else if (rst_on_resp) begin
            rst_v[d] = 1'b0;
            @(negedge clk);
            rst_v[d] = 1'b1;
        end
    endtask

    // Monitor: every response is popped and checked; idle cycles must be quiet
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            n_check++;
            if (rdy_v[k]) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ready dut%0d: got ready=1 err=%0b data=%h, required no response", k, err_v[k], dout_a[k]);
                end else begin
                    m_e   = exp_q.pop_front();
                    m_lat = cyc - m_e.issue + 1;
                    if (m_e.dut != k || err_v[k] !== m_e.err || dout_a[k] !== m_e.data || m_lat != m_e.lat) begin
                        n_fail++;
                        $display("FAIL response dut%0d: got err=%0b data=%h latency=%0d, required dut%0d err=%0b data=%h latency=%0d",
                                 k, err_v[k], dout_a[k], m_lat, m_e.dut, m_e.err, m_e.data, m_e.lat);
                    end
                end
            end else if (err_v[k] !== 1'b0 || dout_a[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_outputs dut%0d: got err=%0b data=%h, required err=0 data=00000000", k, err_v[k], dout_a[k]);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            addr_a[k] = '0; din_a[k] = '0; f3_a[k] = '0;
        end
        repeat (3) @(negedge clk);
        // Reset state on all instances
        for (int k = 0; k < 3; k++) begin
            n_check++;
            if (rdy_v[k] !== 1'b0 || err_v[k] !== 1'b0 || dout_a[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got ready=%0b err=%0b data=%h, required 0/0/00000000", k, rdy_v[k], err_v[k], dout_a[k]);
            end
        end
        rst_v = 3'b111;

        // Write then read back, byte/half loads (WAIT_CYCLES=1)
        do_req(0, WR, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
        do_req(0, RD, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
        do_req(0, RD, F_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b0);
        do_req(0, RD, F_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0, 1'b0);
        do_req(0, RD, F_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0);
        do_req(0, RD, F_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 1'b0);
        do_req(0, RD, F_B,  32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 1'b0);
        do_req(0, RD, F_BU, 32'h10, 32'h0,        32'h000000EF, 1'b0, 1'b0);

        // Partial stores
        do_req(0, WR, F_W,  32'h20, 32'h00000000, 32'h0,        1'b0, 1'b0);
        do_req(0, WR, F_B,  32'h21, 32'h000000AA, 32'h0,        1'b0, 1'b0);
        do_req(0, WR, F_H,  32'h22, 32'h00001234, 32'h0,        1'b0, 1'b0);
        do_req(0, RD, F_W,  32'h20, 32'h0,        32'h1234AA00, 1'b0, 1'b0);

        // Illegal requests leave memory untouched
        do_req(0, WR, F_W,  32'h00,  32'hCAFEF00D, 32'h0,       1'b0, 1'b0);
        do_req(0, RD, F_W,  32'h02,  32'h0,        32'h0,       1'b1, 1'b0);
        do_req(0, WR, F_W,  32'h400, 32'h12345678, 32'h0,       1'b1, 1'b0);
        do_req(0, WR, 3'b111, 32'h10, 32'h11111111, 32'h0,      1'b1, 1'b0);
        do_req(0, WR, F_BU, 32'h10, 32'h22222222, 32'h0,        1'b1, 1'b0);
        do_req(0, WR, F_H,  32'h21, 32'h33333333, 32'h0,        1'b1, 1'b0);
        do_req(0, RD, F_H,  32'h11, 32'h0,        32'h0,        1'b1, 1'b0);
        do_req(0, RD, 3'b011, 32'h10, 32'h0,      32'h0,        1'b1, 1'b0);
        do_req(0, RD, F_W,  32'h00, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0);
        do_req(0, RD, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);

        // Reset during BUSY aborts a store (WAIT_CYCLES=3)
        do_req(1, WR, F_W,  32'h30, 32'h11111111, 32'h0,        1'b0, 1'b0);
        @(negedge clk);
        rw_v[1] = WR; f3_a[1] = F_W; addr_a[1] = 32'h30; din_a[1] = 32'h00000055; en_v[1] = 1'b1;
        @(negedge clk);
        en_v[1] = 1'b0;
        @(negedge clk);
        rst_v[1] = 1'b0;
        @(negedge clk);
        n_check++;
        if (rdy_v[1] !== 1'b0 || err_v[1] !== 1'b0 || dout_a[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset dut1: got ready=%0b err=%0b data=%h, required 0/0/00000000", rdy_v[1], err_v[1], dout_a[1]);
        end
        rst_v[1] = 1'b1;
        repeat (8) @(negedge clk);
        do_req(1, RD, F_W,  32'h30, 32'h0,        32'h11111111, 1'b0, 1'b0);

        // Reset coinciding with the RESP edge suppresses the commit
        do_req(1, WR, F_W,  32'h34, 32'h22222222, 32'h0,        1'b0, 1'b0);
        do_req(1, WR, F_W,  32'h34, 32'h99999999, 32'h0,        1'b0, 1'b1);
        do_req(1, RD, F_W,  32'h34, 32'h0,        32'h22222222, 1'b0, 1'b0);

        // en held high: one transaction every 3 cycles (WAIT_CYCLES=0)
        @(negedge clk);
        rw_v[2] = WR; f3_a[2] = F_W; addr_a[2] = 32'h40; din_a[2] = 32'h000000A0; en_v[2] = 1'b1;
        push_exp(2, 32'h0, 1'b0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            addr_a[2] = 32'h40 + 32'(4 * i);
            din_a[2]  = 32'hA0 + 32'(i);
            @(negedge clk);
            @(negedge clk);
            push_exp(2, 32'h0, 1'b0);
        end
        @(negedge clk);
        en_v[2] = 1'b0;
        repeat (6) @(negedge clk);
        do_req(2, RD, F_W,  32'h40, 32'h0,        32'h000000A0, 1'b0, 1'b0);
        do_req(2, RD, F_W,  32'h44, 32'h0,        32'h000000A1, 1'b0, 1'b0);
        do_req(2, RD, F_W,  32'h48, 32'h0,        32'h000000A2, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        n_check++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
